// File: rtl/core_pkg.sv
// Shared core definitions: widths, reset PC and the fetch->decode entry type.
package core_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;
endpackage

// File: rtl/adder.sv
// Plain W-bit adder; carry out is dropped so results wrap modulo 2^W.
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with a synchronous flush; the head is
// presented combinationally so decode sees it in the cycle it becomes valid.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         enq_valid,
  input  fetch_entry_t enq_data,
  input  logic         deq_valid,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic do_enq;
  logic do_deq;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_enq = enq_valid && (count < CW'(DEPTH));
  assign do_deq = deq_valid && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_deq) rd_ptr <= bump(rd_ptr);
      case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues one outstanding imem
// request at a time and queues returned instructions for decode.
module fetch_stage
  import core_pkg::*;
#(
  parameter int             XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int             FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus_step;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            kill;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            deq;
  logic            accept;
  logic            rsp_take;
  fetch_entry_t    enq_entry;
  fetch_entry_t    head;
  logic            unused_redirect_lsbs;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The sender holds valid and payload stable until that edge; ready may
  // change freely. Responses carry no ready and land one cycle after accept.
  assign deq       = if_valid && if_ready;
  assign accept    = imem_req_valid && imem_req_ready;
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(deq);

  // Gated by rst_n so the combinational request is low the instant reset hits.
  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW + 1)'(FQ_DEPTH));
  assign imem_req_addr  = pc;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign rsp_take = imem_rsp_valid && inflight && !kill;

  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  adder #(XLEN) u_pc_adder (
    .a   (pc),
    .b   (XLEN'(PC_STEP)),
    .sum (pc_plus_step)
  );

  assign enq_entry.pc    = XLEN_DEF'(req_pc);
  assign enq_entry.instr = imem_rsp_data;

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .enq_valid (rsp_take),
    .enq_data  (enq_entry),
    .deq_valid (deq),
    .head      (head),
    .count     (count)
  );

  assign if_valid = (count != '0);
  assign if_pc    = XLEN'(head.pc);
  assign if_instr = head.instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      if (redirect_valid) pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (accept)    pc <= pc_plus_step;

      if (accept) req_pc <= pc;

      if (accept)              inflight <= 1'b1;
      else if (imem_rsp_valid) inflight <= 1'b0;

      // Kill only covers a response still pending after the redirect cycle;
      // one arriving in that cycle is already discarded by the flush.
      if (redirect_valid)      kill <= inflight && !imem_rsp_valid;
      else if (imem_rsp_valid) kill <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle-exact vector table for the directed corner
// cases, then randomized traffic checked against a fetch-order model.
module tb_fetch_stage;
  localparam int XLEN = 32;
  localparam int FQ_DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RST_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int step = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, want %h", name, step, act, exp);
    end
  endtask

  // ---------------- memory model: response exactly one cycle after accept ----------------
  logic        acc_q = 1'b0;
  logic [31:0] acc_addr = 32'h0;

  always @(negedge clk) begin
    acc_q    = rst_n && imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rsp_valid = acc_q;
    imem_rsp_data  = acc_q ? instr_of(acc_addr) : $urandom;
  end

  // Occupancy bound, observed inside the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dut.u_queue.count > FQ_DEPTH) begin
        errors++;
        $display("FAIL queue_bound (step %0d): got %0d, want <= %0d", step, dut.u_queue.count, FQ_DEPTH);
      end
    end
  end

  // ---------------- reference model for random traffic ----------------
  // Requests go out in sequential PC order restarting at each aligned redirect
  // target; accepted PCs join a FIFO that a redirect or reset empties, and
  // decode must see exactly that FIFO's contents in order.
  logic        rnd_on = 1'b0;
  logic [31:0] exp_req;
  logic [31:0] exp_q[$];
  int          handshakes = 0;

  always @(negedge clk) begin
    if (rnd_on) begin
      if (!rst_n) begin
        exp_req = RST_PC;
        exp_q.delete();
      end else if (redirect_valid) begin
        check("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
        exp_req = {redirect_pc[31:2], 2'b00};
        exp_q.delete();
      end else begin
        if (if_valid && if_ready) begin
          handshakes++;
          if (exp_q.size() == 0) begin
            check("if_unexpected", 32'(if_valid), 32'd0);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("if_pc_order", if_pc, e);
            check("if_instr_data", if_instr, instr_of(e));
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr_order", imem_req_addr, exp_req);
          exp_q.push_back(exp_req);
          exp_req = exp_req + 32'd4;
        end
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        rr;
    logic        ifr;
    logic        rd;
    logic [31:0] rpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic rst, input logic rr, input logic ifr, input logic rd,
                         input logic [31:0] rpc, input logic e_rv, input logic [31:0] e_addr,
                         input logic e_iv, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.rr = rr; v.ifr = ifr; v.rd = rd; v.rpc = rpc;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  task automatic apply_row(input vec_t v);
    @(posedge clk);
    #1;
    rst_n          = v.rst;
    imem_req_ready = v.rr;
    if_ready       = v.ifr;
    redirect_valid = v.rd;
    redirect_pc    = v.rpc;
    @(negedge clk);
    check("req_valid", 32'(imem_req_valid), 32'(v.e_rv));
    check("req_addr", imem_req_addr, v.e_addr);
    check("if_valid", 32'(if_valid), 32'(v.e_iv));
    if (v.e_iv) begin
      check("if_pc", if_pc, v.e_pc);
      check("if_instr", if_instr, instr_of(v.e_pc));
    end else if (!v.rst) begin
      check("if_pc_reset", if_pc, 32'h0);
      check("if_instr_reset", if_instr, 32'h0);
    end
  endtask

  task automatic random_cycle();
    @(posedge clk);
    #1;
    imem_req_ready = ($urandom_range(0, 9) < 7);
    if_ready       = ($urandom_range(0, 9) < 7);
    redirect_valid = ($urandom_range(0, 19) == 0);
    redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
  endtask

  initial begin
    //        rst rr ifr rd rpc            rv addr           iv pc
    add_row(0, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
    // reset release with decode stalled: queue fills to two, then issue stops
    add_row(1, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    add_row(1, 1, 0, 0, 32'h0,          1, 32'h4,          0, 32'h0);
    add_row(1, 1, 0, 0, 32'h0,          0, 32'h8,          1, 32'h0);
    add_row(1, 1, 0, 0, 32'h0,          0, 32'h8,          1, 32'h0);
    add_row(1, 1, 0, 0, 32'h0,          0, 32'h8,          1, 32'h0);
    // decode resumes: 0,4,8,... with no gaps and one request per cycle
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'hC,          1, 32'h4);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h10,         1, 32'h8);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h14,         1, 32'hC);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h18,         1, 32'h10);
    // misaligned redirect with a request in flight
    add_row(1, 1, 1, 1, 32'h0000_1002,  0, 32'h1C,         1, 32'h14);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h1000,       0, 32'h0);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h1004,       0, 32'h0);
    add_row(1, 1, 0, 0, 32'h0,          0, 32'h1008,       1, 32'h1000);
    add_row(1, 1, 0, 0, 32'h0,          0, 32'h1008,       1, 32'h1000);
    // asynchronous reset with two queued entries
    add_row(0, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0);
    // restart, then memory not ready for three cycles: address holds at 0x4
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    add_row(1, 0, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0);
    add_row(1, 0, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0);
    add_row(1, 0, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h8,          0, 32'h0);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'hC,          1, 32'h4);
    // redirect near the top of the address space: PC wraps to zero
    add_row(1, 1, 1, 1, 32'hFFFF_FFFA,  0, 32'h10,         1, 32'h8);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'hFFFF_FFF8,  0, 32'h0);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h0,          1, 32'hFFFF_FFF8);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h4,          1, 32'hFFFF_FFFC);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0);
    // back-to-back redirects: the second target wins
    add_row(1, 1, 1, 1, 32'h0000_2000,  0, 32'hC,          1, 32'h4);
    add_row(1, 1, 1, 1, 32'h0000_3004,  0, 32'h2000,       0, 32'h0);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h3004,       0, 32'h0);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h3008,       0, 32'h0);
    add_row(1, 1, 1, 0, 32'h0,          1, 32'h300C,       1, 32'h3004);

    foreach (tbl[i]) begin
      step = i;
      apply_row(tbl[i]);
    end

    // randomized traffic from a fresh reset
    step = 1000;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    rnd_on = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step = 1000 + n;
      random_cycle();
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    rnd_on = 1'b0;
    check("throughput_floor", 32'(handshakes >= 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
